// File: rtl/timer_pkg.sv
// Shared encodings, defaults and preset arithmetic for the timer-set datapath.
package timer_pkg;

    localparam int T_W_DEF      = 10;
    localparam int STEP_SEC_DEF = 10;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        S_HOLD    = 2'b00,
        S_COMPOSE = 2'b01,
        S_CLR     = 2'b10
    } preset_sel_e;

    function automatic logic [31:0] compose_preset(
        input logic [3:0]  tens,
        input logic [3:0]  units,
        input logic [31:0] step
    );
        return ({28'd0, tens} * 32'd10 + {28'd0, units}) * step;
    endfunction

endpackage

// File: rtl/timer_set_datapath_countdown_counter.sv
// Countdown register with run flag and terminal done pulse; stop > load > arm > tick.
module countdown_counter
    import timer_pkg::*;
#(
    parameter int T_W = T_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           arm,
    input  logic           stop,
    input  logic           tick,
    input  logic [T_W-1:0] load_val,
    output logic [T_W-1:0] t,
    output logic           running,
    output logic           done
);

    localparam logic [T_W-1:0] ZERO = {T_W{1'b0}};
    localparam logic [T_W-1:0] ONE  = {{(T_W-1){1'b0}}, 1'b1};

    logic [T_W-1:0] t_q, t_d;
    logic           running_q, running_d;
    logic           done_q, done_d;

    // Next-state priority: stop, load, arm, then tick-driven decrement.
    always_comb begin
        t_d       = t_q;
        running_d = running_q;
        done_d    = 1'b0;
        if (stop) begin
            running_d = 1'b0;
        end else if (load) begin
            t_d = load_val;
            // A reload without arm keeps the run state, but never runs on zero.
            if (arm) begin
                running_d = (load_val != ZERO);
            end else begin
                running_d = running_q && (load_val != ZERO);
            end
        end else if (arm) begin
            running_d = (t_q != ZERO);
        end else if (running_q && tick && (t_q != ZERO)) begin
            t_d = t_q - ONE;
            if (t_q == ONE) begin
                running_d = 1'b0;
                done_d    = 1'b1;
            end else begin
                running_d = running_q;
            end
        end else begin
            t_d = t_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_q       <= ZERO;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            t_q       <= t_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign t       = t_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: rtl/timer_set_datapath.sv
// Timer-set datapath: keypad latch, digit registers, preset composition and countdown.
module timer_set_datapath
    import timer_pkg::*;
#(
    parameter int T_W      = T_W_DEF,
    parameter int STEP_SEC = STEP_SEC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_valid,
    input  logic [3:0]     key_digit,
    input  logic           tick_1hz,
    input  logic           Kc,
    input  logic           La,
    input  logic           Lb,
    input  logic [1:0]     s,
    input  logic           Lr,
    input  logic           Ea,
    input  logic           Er,
    output logic           k7,
    output logic           key_ready,
    output logic           key_err,
    output logic [T_W-1:0] T,
    output logic           running,
    output logic           done
);

    if (32'd99 * STEP_SEC >= (32'd1 << T_W)) begin : g_illegal_params
        $error("timer_set_datapath: 99*STEP_SEC does not fit in T_W bits");
    end

    logic [3:0]     kr_q, kr_d;
    logic           key_ready_q, key_ready_d;
    logic           key_err_q, key_err_d;
    logic [3:0]     a_q, a_d;
    logic [3:0]     b_q, b_d;
    logic [T_W-1:0] p_q, p_d;
    logic           k7_q, k7_d;
    logic [T_W-1:0] p_comp_s;

    assign p_comp_s = T_W'(compose_preset(a_q, b_q, 32'(STEP_SEC)));

    // Key latch: a valid capture beats a same-cycle clear; non-BCD keys only flag an error.
    always_comb begin
        kr_d        = kr_q;
        key_ready_d = key_ready_q;
        key_err_d   = 1'b0;
        if (key_valid && (key_digit <= BCD_MAX)) begin
            kr_d        = key_digit;
            key_ready_d = 1'b1;
        end else if (Kc) begin
            kr_d        = 4'd0;
            key_ready_d = 1'b0;
        end else begin
            kr_d        = kr_q;
        end
        if (key_valid && (key_digit > BCD_MAX)) begin
            key_err_d = 1'b1;
        end else begin
            key_err_d = 1'b0;
        end
    end

    // Digit registers and preset; k7 tracks the preset being written this cycle.
    always_comb begin
        a_d = La ? kr_q : a_q;
        b_d = Lb ? kr_q : b_q;
        p_d = p_q;
        case (s)
            S_HOLD:    p_d = p_q;
            S_COMPOSE: p_d = p_comp_s;
            default:   p_d = {T_W{1'b0}};
        endcase
        k7_d = (p_d != {T_W{1'b0}});
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            kr_q        <= 4'd0;
            key_ready_q <= 1'b0;
            key_err_q   <= 1'b0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            p_q         <= {T_W{1'b0}};
            k7_q        <= 1'b0;
        end else begin
            kr_q        <= kr_d;
            key_ready_q <= key_ready_d;
            key_err_q   <= key_err_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            k7_q        <= k7_d;
        end
    end

    countdown_counter #(
        .T_W (T_W)
    ) u_countdown (
        .clk      (clk),
        .rst      (rst),
        .load     (Lr),
        .arm      (Ea),
        .stop     (Er),
        .tick     (tick_1hz),
        .load_val (p_q),
        .t        (T),
        .running  (running),
        .done     (done)
    );

    assign k7        = k7_q;
    assign key_ready = key_ready_q;
    assign key_err   = key_err_q;

endmodule

// File: tb/tb_timer_set_datapath.sv
// Directed self-checking bench for timer_set_datapath with hand-computed expectations.
module tb_timer_set_datapath;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       tick_1hz;
    logic       Kc, La, Lb, Lr, Ea, Er;
    logic [1:0] s;
    logic       k7, key_ready, key_err, running, done;
    logic [9:0] T;

    int checks = 0;
    int errors = 0;
    int done_count;

    timer_set_datapath #(.T_W(10), .STEP_SEC(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .tick_1hz  (tick_1hz),
        .Kc        (Kc),
        .La        (La),
        .Lb        (Lb),
        .s         (s),
        .Lr        (Lr),
        .Ea        (Ea),
        .Er        (Er),
        .k7        (k7),
        .key_ready (key_ready),
        .key_err   (key_err),
        .T         (T),
        .running   (running),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        key_valid = 1'b0; key_digit = 4'd0; tick_1hz = 1'b0;
        Kc = 1'b0; La = 1'b0; Lb = 1'b0; s = 2'b00;
        Lr = 1'b0; Ea = 1'b0; Er = 1'b0;
    endtask

    // Apply one cycle of strobes, let the edge pass, return inputs to idle.
    task automatic ctl(input logic kc, input logic la, input logic lb, input logic [1:0] sel,
                       input logic lr, input logic ea, input logic er, input logic tk);
        Kc = kc; La = la; Lb = lb; s = sel; Lr = lr; Ea = ea; Er = er; tick_1hz = tk;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic key(input logic [3:0] d, input logic kc);
        key_valid = 1'b1; key_digit = d; Kc = kc;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Enter tens/units digits and compose the preset.
    task automatic set_preset(input logic [3:0] tens, input logic [3:0] units);
        key(tens, 1'b0);
        ctl(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        key(units, 1'b0);
        ctl(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_T", 32'(T), 32'd0);
        check_eq("rst_running", 32'(running), 32'd0);
        check_eq("rst_k7", 32'(k7), 32'd0);
        check_eq("rst_key_ready", 32'(key_ready), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_key_err", 32'(key_err), 32'd0);

        // Entry and compose 47 -> 470.
        key(4'd4, 1'b0);
        check_eq("key4_ready", 32'(key_ready), 32'd1);
        ctl(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        key(4'd7, 1'b0);
        ctl(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("k7_before_compose", 32'(k7), 32'd0);
        ctl(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("k7_after_compose", 32'(k7), 32'd1);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("load470_T", 32'(T), 32'd470);
        check_eq("load470_running", 32'(running), 32'd1);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("stop470_running", 32'(running), 32'd0);

        // Countdown 20 -> 0 with a single done pulse.
        set_preset(4'd0, 4'd2);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("load20_T", 32'(T), 32'd20);
        check_eq("load20_running", 32'(running), 32'd1);
        done_count = 0;
        for (int i = 1; i <= 20; i++) begin
            ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
            if (done) done_count++;
            check_eq("cd_T", 32'(T), 32'(20 - i));
            check_eq("cd_done", 32'(done), 32'(i == 20));
            check_eq("cd_running", 32'(running), 32'(i != 20));
            ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            if (done) done_count++;
        end
        check_eq("cd_done_count", 32'(done_count), 32'd1);
        for (int i = 0; i < 2; i++) begin
            ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
            check_eq("cd_nowrap_T", 32'(T), 32'd0);
            check_eq("cd_nowrap_done", 32'(done), 32'd0);
        end

        // Er beats Ea; Ea alone re-arms; ticks ignored while stopped.
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("er_ea_running", 32'(running), 32'd0);
        check_eq("er_ea_T", 32'(T), 32'd20);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("ea_rearm_running", 32'(running), 32'd1);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("tick_T19", 32'(T), 32'd19);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("stopped_tick_T", 32'(T), 32'd19);
        check_eq("stopped_tick_running", 32'(running), 32'd0);

        // Lr beats a same-cycle tick: T=5, P=30.
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("pre_load_T5", 32'(T), 32'd5);
        set_preset(4'd0, 4'd3);
        check_eq("p30_T_held", 32'(T), 32'd5);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("lr_tick_T", 32'(T), 32'd30);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-countdown at T=37.
        set_preset(4'd0, 4'd4);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("pre_rst_T37", 32'(T), 32'd37);
        rst = 1'b1; tick_1hz = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; tick_1hz = 1'b0;
        check_eq("midrst_T", 32'(T), 32'd0);
        check_eq("midrst_running", 32'(running), 32'd0);
        check_eq("midrst_k7", 32'(k7), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check_eq("midrst_done_next", 32'(done), 32'd0);

        // Zero preset: k7 drops, Lr+Ea does not run.
        set_preset(4'd5, 4'd5);
        check_eq("k7_p550", 32'(k7), 32'd1);
        set_preset(4'd0, 4'd0);
        check_eq("k7_p0", 32'(k7), 32'd0);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("zero_lr_running", 32'(running), 32'd0);
        check_eq("zero_lr_T", 32'(T), 32'd0);
        check_eq("zero_lr_done", 32'(done), 32'd0);

        // Clear encodings 10 and 11.
        set_preset(4'd1, 4'd2);
        check_eq("k7_p120", 32'(k7), 32'd1);
        ctl(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("k7_s10", 32'(k7), 32'd0);
        set_preset(4'd1, 4'd2);
        ctl(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("k7_s11", 32'(k7), 32'd0);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("k7_hold", 32'(k7), 32'd0);

        // Non-BCD key: error pulse, latch keeps 5 -> preset 550.
        key(4'd5, 1'b0);
        key(4'd12, 1'b0);
        check_eq("bad_key_err", 32'(key_err), 32'd1);
        check_eq("bad_key_ready", 32'(key_ready), 32'd1);
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("bad_key_err_drop", 32'(key_err), 32'd0);
        ctl(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("bad_key_T550", 32'(T), 32'd550);

        // Kc alone clears; capture beats same-cycle Kc -> A=3, B=0 -> 300.
        ctl(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("kc_ready", 32'(key_ready), 32'd0);
        key(4'd3, 1'b1);
        check_eq("key_kc_ready", 32'(key_ready), 32'd1);
        ctl(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        ctl(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("key_kc_T300", 32'(T), 32'd300);
        check_eq("key_kc_running", 32'(running), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_set_datapath.md
Name: timer_set_datapath

Overview:
- Datapath responder for the timer-set controller. Consumes its one-hot control strobes (Kc, La, Lb, Ea, Lr, Er, s) and returns the k7 status flag that steers the controller's state-7 branch.
- Captures keypad digits, composes a preset in seconds, loads it into a countdown counter and decrements it on a 1 Hz tick. Reports remaining time and a done pulse to the display and alarm logic.

Parameters:
- T_W, 10, width of preset and countdown registers.
- STEP_SEC, 10, seconds per preset unit; preset = (A*10+B)*STEP_SEC.
- Legality: 99*STEP_SEC must be < 2**T_W. The implementation checks this at elaboration.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- key_valid  in  1  one-cycle strobe: key_digit is valid.
- key_digit  in  4  BCD keypad digit.
- tick_1hz  in  1  one-cycle 1 Hz enable.
- Kc  in  1  clear key latch.
- La  in  1  load tens digit register A from key latch.
- Lb  in  1  load units digit register B from key latch.
- s  in  2  preset operation select.
- Lr  in  1  load countdown T from preset P.
- Ea  in  1  arm countdown (run enable).
- Er  in  1  stop countdown.
- k7  out  1  status to controller: preset valid (P != 0).
- key_ready  out  1  key latch holds an unconsumed digit.
- key_err  out  1  one-cycle pulse on a rejected non-BCD key.
- T  out  T_W  remaining seconds.
- running  out  1  countdown active.
- done  out  1  one-cycle pulse when T reaches 0.

Behaviour:
- Single clock domain; all state updates on posedge clk. Every output is registered. No combinational path from any input to any output.
- Reset (rst=1 at posedge) has priority over everything. It clears KR, key_ready, A, B, P, T, running, done, key_err and k7 to 0. Reset mid-countdown aborts the countdown with no done pulse.
- Key latch KR[3:0]:
  - key_valid with key_digit<=9: KR<=key_digit, key_ready<=1.
  - key_valid with key_digit>9: KR unchanged, key_err pulses 1 cycle.
  - Kc alone: KR<=0, key_ready<=0.
  - key_valid and Kc in the same cycle: capture wins (KR<=digit, key_ready=1).
- Digit registers:
  - La: A<=KR. Lb: B<=KR. Both load regardless of key_ready.
  - La and Lb in the same cycle: both load the same KR.
- Preset P, driven by s:
  - 00: hold.
  - 01: P<=(A*10+B)*STEP_SEC. Computed at full width and truncated to T_W; no truncation occurs when the parameter is legal.
  - 10 and 11: P<=0.
- k7 <= (next P != 0). It is registered and reflects P one cycle after the s=01 update, so the controller sees it when it reaches state 7.
- Countdown. Priority per cycle:
  1. Er: running<=0, T holds. Er beats Ea when both are asserted.
  2. Lr: T<=P. If Ea is also asserted, running<=(P!=0); Lr with P=0 leaves running=0 and produces no done. Lr beats a same-cycle tick.
  3. Ea alone: running<=(T!=0).
  4. running && tick_1hz: T<=T-1. If T==1 this cycle, then T<=0, running<=0, done<=1 for one cycle.
- Never wraps: T=0 is never decremented.
- Ticks while running=0 are ignored.
- done is 0 in every other cycle.

Decomposition:
- Shared package timer_pkg holds:
  - the s encodings: S_HOLD=2'b00, S_COMPOSE=2'b01, S_CLR=2'b10;
  - the default T_W and STEP_SEC;
  - the BCD_MAX=9 constant.
- One natural sub-module, countdown_counter: T register, running flag, done pulse and the priority logic. It takes load, arm, stop, tick and the load value as inputs.
- Key latch, digit registers and preset arithmetic stay in the top module.

Test Plan:
- Reset: rst=1 mid-countdown with T=37 -> next cycle T=0, running=0, k7=0, no done pulse.
- Entry and compose: key 4, La, key 7, Lb, s=01 -> P=470 (47*10); k7=1 one cycle after the compose.
- Zero preset: A=0, B=0, s=01 -> P=0 and k7=0. Then Lr+Ea -> running stays 0 and no done pulse.
- Countdown to done: P=20, Lr+Ea, then 20 ticks -> T steps 20..1..0; done pulses exactly once on the 20th tick; running=0; further ticks leave T=0.
- Priority: Er+Ea in the same cycle -> running=0. Lr with a tick in the same cycle while T=5, P=30 -> T=30 (load wins).
- Key corner cases: key_valid=1 with digit 12 -> key_err pulses and KR is unchanged. key_valid (digit 3) with Kc in the same cycle -> KR=3, key_ready=1.
